alu_mc: RTL
===========

Name: alu_mc

Overview:
- Parametrised multi-cycle ALU: successor to the single-cycle combinational ALU in the RISC-V datapath.
- Generalised operand width and a wider opcode set: XOR, SLTU, shifts, plus iterative MUL/DIVU/REMU.
- Valid/ready handshake on both sides, so the core can stall on long operations.
- Result and zero flag are registered; sits between the decode/operand-select stage and writeback.

Parameters:
- WIDTH, 32, operand/result width; power of two, minimum 8.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  synchronous reset, active-low.
- i_valid  in  1  operation request.
- o_ready  out  1  block can accept a request this cycle.
- i_srcA  in  WIDTH  operand A.
- i_srcB  in  WIDTH  operand B.
- i_alu_control  in  4  opcode.
- o_valid  out  1  o_ALU/o_zero hold a completed result.
- i_ready  in  1  consumer takes the result.
- o_ALU  out  WIDTH  registered result.
- o_zero  out  1  1 when o_ALU == 0.
- o_busy  out  1  iterative operation in progress.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous, active-low, on i_rst_n; sampled only on the rising edge of i_clk.
- Reset values: state IDLE; o_valid=0; o_busy=0; o_ALU=0; o_zero=1; all internal iteration registers 0.
- Reset while BUSY or DONE aborts the operation; no o_valid is produced for it.
- Opcodes:
  - 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 XOR.
  - 0101 SLT (signed); 0110 SLTU: result 1 or 0, zero-extended.
  - 0111 SLL; 1000 SRL; 1001 SRA. Shift amount = i_srcB[SHW-1:0].
  - 1010 MUL: low WIDTH bits of A*B.
  - 1011 DIVU: unsigned quotient.
  - 1100 REMU: unsigned remainder.
  - 1101-1111: result 0, single-cycle.
- Arithmetic wraps modulo 2^WIDTH; no overflow flag.
- o_zero is derived from the registered o_ALU; it is always consistent with o_ALU, including at reset.
- States:
  - IDLE: o_ready=1.
    - i_valid with a single-cycle op (or 1101-1111): latch result, go to DONE.
    - i_valid with MUL/DIVU/REMU: capture operands, clear counter, go to BUSY.
  - BUSY: o_ready=0, o_busy=1.
    - MUL: shift-add, one multiplier bit per cycle.
    - DIVU/REMU: restoring division, one quotient bit per cycle.
    - After exactly WIDTH BUSY cycles, write the result to o_ALU and go to DONE.
  - DONE: o_valid=1; o_ALU/o_zero held stable until i_ready=1.
    - i_ready=1 and i_valid=0: go to IDLE.
    - o_ready = i_ready in DONE (combinational), allowing back-to-back issue.
    - i_ready=1 and i_valid=1: accept the new op in the same cycle, following the IDLE rules.
- Latency, request accepted at edge N:
  - Single-cycle ops: o_valid=1 after edge N+1.
  - Iterative ops: o_valid=1 after edge N+WIDTH+1.
  - Throughput for single-cycle ops with i_ready held 1: one result per clock.
- Divide by zero: not iterated; completes with single-cycle latency. DIVU gives all ones; REMU gives i_srcA.
- Inputs are sampled only on the accept edge. Changes to i_srcA/i_srcB/i_alu_control while BUSY/DONE have no effect.
- i_valid while o_ready=0 is ignored; the requester must hold the request.
- o_valid never asserts for a dropped request.

Optional Feature:
- Macro: ALU_MULDIV_EN.
- Defined: MUL/DIVU/REMU behave as above; BUSY state and iteration datapath are present.
- Not defined:
  - Opcodes 1010-1100 are treated as undefined: result 0, single-cycle latency.
  - No BUSY state, no iteration registers; o_busy is tied to 0.

Test Plan:
- Reset then idle, WIDTH=32: hold i_rst_n=0 two cycles, release -> o_valid=0, o_ALU=0, o_zero=1, o_ready=1.
- Back-to-back single-cycle ops, i_ready=1, one per clock:
  - ADD 5+7 -> 12.
  - SUB 7-7 -> 0 with o_zero=1.
  - SLT 0xFFFFFFFF,1 -> 1.
  - SLTU 0xFFFFFFFF,1 -> 0.
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - Each result 1 cycle after accept, no bubbles.
- MUL 0x0001_0003 * 0x0000_0010 -> 0x0010_0030.
  - o_busy=1 for exactly 32 cycles; o_valid 33 cycles after accept.
  - i_valid pulses while BUSY are ignored.
- DIVU 100/7 -> 14; REMU 100/7 -> 2.
  - Divide by zero: DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9, both 1-cycle latency.
- Backpressure: hold i_ready=0 for 5 cycles after a result.
  - o_valid and o_ALU stay stable; o_ready=0.
  - Raising i_ready with i_valid=1 accepts the next op that same cycle.
- Reset mid-DIVU at iteration 10 -> IDLE next cycle, o_valid=0, o_busy=0; a new ADD 1+1 then returns 2.
  - Repeat with ALU_MULDIV_EN undefined: MUL 3*4 -> 0 in 1 cycle, o_busy never 1.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on both sides and a registered result/zero flag.
// Define ALU_MULDIV_EN to build the iterative MUL/DIVU/REMU datapath (shift-add and restoring division).
module alu_mc #(
   parameter int WIDTH = 32,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_srcA,
   input  logic [WIDTH-1:0] i_srcB,
   input  logic [3:0]       i_alu_control,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_ALU,
   output logic             o_zero,
   output logic             o_busy
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SLT  = 4'b0101;
   localparam logic [3:0] OP_SLTU = 4'b0110;
   localparam logic [3:0] OP_SLL  = 4'b0111;
   localparam logic [3:0] OP_SRL  = 4'b1000;
   localparam logic [3:0] OP_SRA  = 4'b1001;
`ifdef ALU_MULDIV_EN
   localparam logic [3:0] OP_MUL  = 4'b1010;
   localparam logic [3:0] OP_DIVU = 4'b1011;
   localparam logic [3:0] OP_REMU = 4'b1100;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
`else
   typedef enum logic {IDLE, DONE} state_e;
`endif

   state_e           state_q, state_d;
   logic [WIDTH-1:0] alu_q, alu_d;
   logic             accept;

   // Results that complete in the accept cycle; DIVU/REMU only land here with a zero divisor.
   function automatic logic [WIDTH-1:0] singleOp(input logic [3:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
      logic [SHW-1:0] sh;
      sh = b[SHW-1:0];
      singleOp = '0;
      case (op)
         OP_ADD:  singleOp = a + b;
         OP_SUB:  singleOp = a - b;
         OP_AND:  singleOp = a & b;
         OP_OR:   singleOp = a | b;
         OP_XOR:  singleOp = a ^ b;
         OP_SLT:  singleOp = WIDTH'($signed(a) < $signed(b));
         OP_SLTU: singleOp = WIDTH'(a < b);
         OP_SLL:  singleOp = a << sh;
         OP_SRL:  singleOp = a >> sh;
         OP_SRA:  singleOp = $unsigned($signed(a) >>> sh);
`ifdef ALU_MULDIV_EN
         OP_DIVU: singleOp = '1;
         OP_REMU: singleOp = a;
`endif
         default: singleOp = '0;
      endcase
   endfunction

   assign o_ready = (state_q == IDLE) || ((state_q == DONE) && i_ready);
   assign accept  = i_valid && o_ready;
   assign o_valid = (state_q == DONE);
   assign o_ALU   = alu_q;
   assign o_zero  = (alu_q == '0);

`ifdef ALU_MULDIV_EN
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] opA_q, opA_d;
   logic [WIDTH-1:0] opB_q, opB_d;
   logic [SHW-1:0]   count_q, count_d;
   logic             isMul_q, isMul_d;
   logic             isRem_q, isRem_d;
   logic             startIter;
   logic [WIDTH-1:0] accStep, opAStep, opBStep;
   logic [WIDTH:0]   remShift;
   logic             remGeq;

   assign startIter = (i_alu_control == OP_MUL) ||
                      (((i_alu_control == OP_DIVU) || (i_alu_control == OP_REMU)) && (i_srcB != '0));
   assign o_busy    = (state_q == BUSY);

   // acc holds the product (MUL) or partial remainder (DIVU/REMU); opA shifts dividend bits out
   // while quotient bits shift in from the bottom.
   always_comb begin
      accStep  = acc_q;
      opAStep  = opA_q;
      opBStep  = opB_q;
      remShift = '0;
      remGeq   = 1'b0;
      if (isMul_q) begin
         accStep = opB_q[0] ? (acc_q + opA_q) : acc_q;
         opAStep = opA_q << 1;
         opBStep = opB_q >> 1;
      end else begin
         remShift = {acc_q, opA_q[WIDTH-1]};
         remGeq   = (remShift >= {1'b0, opB_q});
         accStep  = remGeq ? (remShift[WIDTH-1:0] - opB_q) : remShift[WIDTH-1:0];
         opAStep  = {opA_q[WIDTH-2:0], remGeq};
      end
   end

   // Next-state logic; a new request accepted from IDLE or DONE overrides the hold/retire paths.
   always_comb begin
      state_d = state_q;
      alu_d   = alu_q;
      acc_d   = acc_q;
      opA_d   = opA_q;
      opB_d   = opB_q;
      count_d = count_q;
      isMul_d = isMul_q;
      isRem_d = isRem_q;
      case (state_q)
         IDLE: ;
         BUSY: begin
            acc_d   = accStep;
            opA_d   = opAStep;
            opB_d   = opBStep;
            count_d = count_q + 1'b1;
            if (count_q == SHW'(WIDTH - 1)) begin
               alu_d   = (isMul_q || isRem_q) ? accStep : opAStep;
               state_d = DONE;
            end
         end
         DONE: begin
            if (i_ready && !i_valid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (accept) begin
         if (startIter) begin
            acc_d   = '0;
            opA_d   = i_srcA;
            opB_d   = i_srcB;
            count_d = '0;
            isMul_d = (i_alu_control == OP_MUL);
            isRem_d = (i_alu_control == OP_REMU);
            state_d = BUSY;
         end else begin
            alu_d   = singleOp(i_alu_control, i_srcA, i_srcB);
            state_d = DONE;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         acc_q   <= '0;
         opA_q   <= '0;
         opB_q   <= '0;
         count_q <= '0;
         isMul_q <= 1'b0;
         isRem_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         opA_q   <= opA_d;
         opB_q   <= opB_d;
         count_q <= count_d;
         isMul_q <= isMul_d;
         isRem_q <= isRem_d;
      end
   end
`else
   assign o_busy = 1'b0;

   always_comb begin
      state_d = state_q;
      alu_d   = alu_q;
      if ((state_q == DONE) && i_ready && !i_valid) state_d = IDLE;
      if (accept) begin
         alu_d   = singleOp(i_alu_control, i_srcA, i_srcB);
         state_d = DONE;
      end
   end
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         alu_q   <= '0;
      end else begin
         state_q <= state_d;
         alu_q   <= alu_d;
      end
   end

endmodule
